// File: rtl/brushless_ctrl.sv
// BLDC commutation controller: hall sync, per-period rotor latch, phase selects, duty.
// Optional out-of-sequence hall step detector built when HALL_DIR_CHECK_EN is defined.
module brushless_ctrl #(
  parameter logic [10:0] DUTY_OFFSET    = 11'h158,
  parameter int          HALL_ERR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] drv_mag,
  input  logic        hallGrn,
  input  logic        hallYlw,
  input  logic        hallBlu,
  input  logic        brake_n,
  input  logic        PWM_synch,
  output logic [10:0] duty,
  output logic [1:0]  selGrn,
  output logic [1:0]  selYlw,
  output logic [1:0]  selBlu,
  output logic        hall_err,
  output logic        dir_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_BRAKE = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [3:0] ERR_LIM = 4'(HALL_ERR_LIMIT);

  function automatic logic legal(input logic [2:0] h);
    return (h != 3'b000) && (h != 3'b111);
  endfunction

  logic [2:0]  hs1_q, hs1_d;
  logic [2:0]  hs2_q, hs2_d;
  logic [2:0]  rot_q, rot_d;
  logic [1:0]  state_q, state_d;
  logic [3:0]  err_q, err_d;
  logic [10:0] duty_q, duty_d;
  logic [2:0]  hall_s;
  logic [3:0]  err_inc;
  logic [11:0] sum;
  logic [10:0] sat;
  logic [5:0]  sel;
  logic        unused_bits;

  assign hall_s      = hs2_q;
  assign err_inc     = err_q + 4'd1;
  assign unused_bits = ^drv_mag[1:0];

  always_comb begin
    hs1_d = {hallGrn, hallYlw, hallBlu};
    hs2_d = hs1_q;
    rot_d = PWM_synch ? hall_s : rot_q;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        err_d = 4'd0;
        if (PWM_synch && legal(hall_s))
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (PWM_synch) begin
          if (legal(hall_s)) begin
            err_d = 4'd0;
          end else begin
            err_d = err_inc;
            if (err_inc >= ERR_LIM)
              state_d = ST_FAULT;
          end
        end
      end
      ST_BRAKE: begin
        err_d = 4'd0;
        if (brake_n)
          state_d = ST_IDLE;
      end
      default: ;
    endcase
    if (!brake_n)
      state_d = ST_BRAKE;
  end

  // 12-bit sum so an overflow past 11 bits clips instead of wrapping
  always_comb begin
    sum = {1'b0, DUTY_OFFSET} + {2'b00, drv_mag[11:2]};
    sat = sum[11] ? 11'h7FF : sum[10:0];
    unique case (1'b1)
      state_d == ST_RUN:   duty_d = sat;
      state_d == ST_BRAKE: duty_d = 11'h600;
      default:             duty_d = 11'h000;
    endcase
  end

  always_comb begin
    sel = 6'b00_00_00;
    if (state_q == ST_BRAKE) begin
      sel = 6'b11_11_11;
    end else if (state_q == ST_RUN) begin
      case (rot_q)
        3'b101:  sel = 6'b10_01_00;
        3'b100:  sel = 6'b10_00_01;
        3'b110:  sel = 6'b00_10_01;
        3'b010:  sel = 6'b01_10_00;
        3'b011:  sel = 6'b01_00_10;
        3'b001:  sel = 6'b00_01_10;
        default: sel = 6'b00_00_00;
      endcase
    end
  end

  assign {selGrn, selYlw, selBlu} = sel;
  assign duty     = duty_q;
  assign hall_err = (state_q == ST_FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1_q   <= 3'b000;
      hs2_q   <= 3'b000;
      rot_q   <= 3'b000;
      state_q <= ST_IDLE;
      err_q   <= 4'd0;
      duty_q  <= 11'h000;
    end else begin
      hs1_q   <= hs1_d;
      hs2_q   <= hs2_d;
      rot_q   <= rot_d;
      state_q <= state_d;
      err_q   <= err_d;
      duty_q  <= duty_d;
    end
  end

`ifdef HALL_DIR_CHECK_EN
  function automatic logic [2:0] pos(input logic [2:0] h);
    case (h)
      3'b101:  return 3'd0;
      3'b100:  return 3'd1;
      3'b110:  return 3'd2;
      3'b010:  return 3'd3;
      3'b011:  return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  logic       dir_err_q, dir_err_d;
  logic [2:0] p_old, p_new, p_fwd, p_bwd;

  always_comb begin
    p_old     = pos(rot_q);
    p_new     = pos(hall_s);
    p_fwd     = (p_old == 3'd5) ? 3'd0 : p_old + 3'd1;
    p_bwd     = (p_old == 3'd0) ? 3'd5 : p_old - 3'd1;
    dir_err_d = 1'b0;
    if (state_q == ST_RUN && PWM_synch &&
        legal(rot_q) && legal(hall_s) &&
        rot_q != hall_s &&
        p_new != p_fwd && p_new != p_bwd)
      dir_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_err_q <= 1'b0;
    else        dir_err_q <= dir_err_d;
  end

  assign dir_err = dir_err_q;
`else
  assign dir_err = 1'b0;
`endif

endmodule

// File: tb/tb_brushless_ctrl.sv
// Scoreboard bench for brushless_ctrl: expectations queued at stimulus,
// popped and compared after the DUT has reacted.
module tb_brushless_ctrl;

`ifdef HALL_DIR_CHECK_EN
  localparam logic DIR_ON = 1'b1;
`else
  localparam logic DIR_ON = 1'b0;
`endif

  localparam logic [5:0] S101 = 6'b10_01_00;
  localparam logic [5:0] S100 = 6'b10_00_01;
  localparam logic [5:0] S110 = 6'b00_10_01;
  localparam logic [5:0] S010 = 6'b01_10_00;
  localparam logic [5:0] S011 = 6'b01_00_10;
  localparam logic [5:0] S001 = 6'b00_01_10;
  localparam logic [5:0] SOFF = 6'b00_00_00;
  localparam logic [5:0] SBRK = 6'b11_11_11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] drv_mag;
  logic        hallGrn, hallYlw, hallBlu;
  logic        brake_n, PWM_synch;
  logic [10:0] duty, duty_s;
  logic [1:0]  selGrn, selYlw, selBlu;
  logic [1:0]  sg_s, sy_s, sb_s;
  logic        hall_err, dir_err, he_s, de_s;

  always #5 clk = ~clk;

  brushless_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .drv_mag(drv_mag),
    .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
    .brake_n(brake_n), .PWM_synch(PWM_synch), .duty(duty),
    .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
    .hall_err(hall_err), .dir_err(dir_err)
  );

  brushless_ctrl #(.DUTY_OFFSET(11'h500)) u_sat (
    .clk(clk), .rst_n(rst_n), .drv_mag(drv_mag),
    .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
    .brake_n(brake_n), .PWM_synch(PWM_synch), .duty(duty_s),
    .selGrn(sg_s), .selYlw(sy_s), .selBlu(sb_s),
    .hall_err(he_s), .dir_err(de_s)
  );

  typedef struct packed {
    logic [5:0]  sel;
    logic [10:0] duty;
    logic        herr;
    logic        derr;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [5:0] s,
                      input logic [10:0] d, input logic he,
                      input logic de);
    exp_t e;
    e.sel  = s;
    e.duty = d;
    e.herr = he;
    e.derr = de;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    exp_t  e;
    string t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, ".sel"}, 32'({selGrn, selYlw, selBlu}), 32'(e.sel));
      chk({t, ".duty"}, 32'(duty), 32'(e.duty));
      chk({t, ".herr"}, 32'(hall_err), 32'(e.herr));
      chk({t, ".derr"}, 32'(dir_err), 32'(e.derr));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic halls(input logic [2:0] h);
    {hallGrn, hallYlw, hallBlu} = h;
    step();
    step();
  endtask

  task automatic strobe_chk(input string tag, input logic [5:0] s,
                            input logic [10:0] d, input logic he,
                            input logic de);
    PWM_synch = 1'b1;
    push(tag, s, d, he, de);
    step();
    PWM_synch = 1'b0;
    drain();
  endtask

  task automatic clk_chk(input string tag, input logic [5:0] s,
                         input logic [10:0] d, input logic he,
                         input logic de);
    push(tag, s, d, he, de);
    step();
    drain();
  endtask

  logic [2:0] walk_h [6];
  logic [5:0] walk_s [6];

  initial begin
    walk_h = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
    walk_s = '{S100, S110, S010, S011, S001, S101};

    rst_n = 1'b0;
    drv_mag = 12'h400;
    {hallGrn, hallYlw, hallBlu} = 3'b101;
    brake_n = 1'b1;
    PWM_synch = 1'b0;
    step();
    step();
    push("rst", SOFF, 11'h0, 1'b0, 1'b0);
    drain();

    rst_n = 1'b1;
    step();
    clk_chk("idle", SOFF, 11'h0, 1'b0, 1'b0);
    step();
    strobe_chk("run0", S101, 11'h258, 1'b0, 1'b0);
    chk("sat.600", 32'(duty_s), 32'h600);

    for (int i = 0; i < 6; i++) begin
      {hallGrn, hallYlw, hallBlu} = walk_h[i];
      push("hold", (i == 0) ? S101 : walk_s[i-1], 11'h258, 1'b0, 1'b0);
      step();
      step();
      drain();
      strobe_chk("walk", walk_s[i], 11'h258, 1'b0, 1'b0);
    end

    halls(3'b110);
    strobe_chk("jump", S110, 11'h258, 1'b0, DIR_ON);
    clk_chk("jump_clr", S110, 11'h258, 1'b0, 1'b0);
    halls(3'b100);
    strobe_chk("adj", S100, 11'h258, 1'b0, 1'b0);

    drv_mag = 12'hFFF;
    clk_chk("mag_fff", S100, 11'h557, 1'b0, 1'b0);
    chk("sat.clip", 32'(duty_s), 32'h7FF);
    drv_mag = 12'h000;
    clk_chk("mag_0", S100, 11'h158, 1'b0, 1'b0);
    drv_mag = 12'h400;
    clk_chk("mag_400", S100, 11'h258, 1'b0, 1'b0);

    halls(3'b111);
    for (int k = 0; k < 3; k++) begin
      strobe_chk("ill3", SOFF, 11'h258, 1'b0, 1'b0);
      step();
    end
    halls(3'b101);
    strobe_chk("recover", S101, 11'h258, 1'b0, 1'b0);

    halls(3'b111);
    for (int k = 0; k < 3; k++) begin
      strobe_chk("ill_pre", SOFF, 11'h258, 1'b0, 1'b0);
      step();
    end
    strobe_chk("fault", SOFF, 11'h0, 1'b1, 1'b0);
    halls(3'b101);
    strobe_chk("fault_hold", SOFF, 11'h0, 1'b1, 1'b0);

    brake_n = 1'b0;
    clk_chk("brk_fault", SBRK, 11'h600, 1'b0, 1'b0);
    clk_chk("brk_hold", SBRK, 11'h600, 1'b0, 1'b0);
    brake_n = 1'b1;
    clk_chk("rel_fault", SOFF, 11'h0, 1'b0, 1'b0);
    strobe_chk("rerun", S101, 11'h258, 1'b0, 1'b0);

    step();
    brake_n = 1'b0;
    clk_chk("brk_run", SBRK, 11'h600, 1'b0, 1'b0);
    brake_n = 1'b1;
    clk_chk("rel_run", SOFF, 11'h0, 1'b0, 1'b0);
    strobe_chk("rerun1", S101, 11'h258, 1'b0, 1'b0);

    halls(3'b100);
    brake_n = 1'b0;
    strobe_chk("brk_pwm", SBRK, 11'h600, 1'b0, 1'b0);
    brake_n = 1'b1;
    clk_chk("rel_pwm", SOFF, 11'h0, 1'b0, 1'b0);
    strobe_chk("rerun2", S100, 11'h258, 1'b0, 1'b0);

    #2;
    rst_n = 1'b0;
    #1;
    push("arst", SOFF, 11'h0, 1'b0, 1'b0);
    drain();
    step();
    rst_n = 1'b1;
    halls(3'b111);
    step();
    strobe_chk("idle_ill", SOFF, 11'h0, 1'b0, 1'b0);
    halls(3'b011);
    strobe_chk("idle_run", S011, 11'h258, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
